line_option_parser: RTL and testbench
=====================================

# line_option_parser

Parametrised successor to the fixed 11x11 nonogram byte parser. Consumes the UART byte stream of two-byte messages (header + payload), builds each candidate line option as a MAX_N-bit vector, and streams options one at a time to the solver's option BRAM writer with valid/ready backpressure. It adds board-size parameters, in-line cell addressing, per-line option counts, protocol error detection, and resynchronisation on the next START_BOARD.

## Interface
- MAX_N, 16: maximum board dimension; legal range 2..31.
- OPT_W, 8: width of the per-line option counter.
- LINE_W, $clog2(2*MAX_N): width of the line index; lines 0..m-1 are rows, m..m+n-1 are columns.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- opt_valid  out  1  option word held.
- opt_ready  in  1  consumer accepts the word.
- opt_bits  out  MAX_N  option cells; bit i is cell i of the line; unwritten cells read 0.
- opt_line  out  LINE_W  line index of the option.
- opt_last  out  1  last option of the line.
- cnt_valid  out  1  one-cycle pulse at END_LINE.
- cnt_line  out  LINE_W  line index for cnt_valid.
- cnt_value  out  OPT_W  number of options in that line.
- m, n  out  5 each  rows and columns from START_BOARD.
- board_done  out  1  one-cycle pulse on END_BOARD.
- err  out  1  sticky protocol error; cleared by rst or an accepted START_BOARD header.

## Operation
- Framing:
  - Bytes alternate header/payload. A phase bit toggles on each accepted byte.
  - Header [7:5] is the flag and [4:0] is hdr_arg.
  - The phase bit is forced to header by rst and by error recovery.
- Flags:
  - START_BOARD 111: m = hdr_arg, n = payload[4:0]. Clears the option accumulator and err.
  - START_LINE 110: line = payload; clears accumulator and count.
  - AND 101: cell position = payload[7:1]; value = payload[0]; sets or clears that bit.
  - OR 010: emits the accumulator with last=0, count+1, then clears the accumulator.
  - END_LINE 001: emits with last=1, count+1, pulses cnt_valid.
  - END_BOARD 000: pulses board_done.
  - 011 and 100 are illegal.
- FSM states are IDLE, BOARD, LINE, ERROR. Reset state is IDLE.
  - IDLE: accepts only START_BOARD, which moves to BOARD. Any other message is ignored without error.
  - BOARD: START_LINE moves to LINE. END_BOARD moves to IDLE. START_BOARD restarts the board.
  - LINE: AND, OR and END_LINE are legal. END_LINE moves to BOARD.
- Errors (set err and move to ERROR):
  - illegal flag;
  - AND, OR or END_LINE outside LINE;
  - START_LINE or END_BOARD inside LINE;
  - line index >= m+n;
  - cell position >= line length (n for rows, m for columns);
  - count overflowing 2^OPT_W-1;
  - m or n equal to 0 or greater than MAX_N.
- ERROR state:
  - Discards bytes while in_ready stays 1.
  - Every accepted byte is checked against 111xxxxx. A match becomes the START_BOARD header and the next byte becomes its payload.
  - No emission occurs in ERROR.

## Timing
- Reset values:
  - in_ready=1; all other outputs are 0.
  - Internal state: IDLE, header phase, accumulator 0.
- A message acts on the cycle its payload byte is accepted. Registered outputs (opt_*, cnt_*, board_done, m, n, err) update on the next edge.
- Latency from payload acceptance to opt_valid is 1 cycle.
- Output register:
  - One entry. opt_* are held stable while opt_valid && !opt_ready.
  - in_ready = !opt_valid || opt_ready. This is a combinational path from opt_ready.
  - When in_ready=0, no byte is accepted and no state changes.
- Simultaneous events: a word drains and a new emission loads in the same cycle, giving back-to-back words at full rate.
- rst mid-line drops any held option word.

## Structure
- Put in package nonogram_pkg:
  - flag localparams FLAG_START_BOARD…FLAG_OR;
  - typedef enum parse_state_t {IDLE, BOARD, LINE, ERROR}.
- Use one sub-module, option_out_reg: the one-entry valid/ready holding register for {opt_bits, opt_line, opt_last}.

## Test plan
- 3x3 board:
  - Stimulus: E3 03, C0 00, A0 01, A0 05, 40 00, A0 03, 20 00, 00 00.
  - Response: m=3, n=3; word (bits=101, line 0, last 0); word (bits=010, line 0, last 1); cnt_valid with line 0, value 2; board_done pulse; err=0.
- Backpressure: opt_ready held 0 for 5 cycles after the first emission. in_ready drops to 0, the second word is not lost or reordered, and both words arrive intact once opt_ready=1.
- Range error: on a 3x3 board, AND A0 07 (position 3). err=1, no word emitted. Subsequent bytes are discarded until E3 03, which clears err and parses the next board normally.
- Illegal flag 0x60 in LINE: err=1. Then in_byte=E2, 02 yields m=2, n=2 and err=0.
- Count overflow with OPT_W=2: four ORs then END_LINE. err=1 on the 4th OR; exactly 3 words are emitted.
- Mid-line reset: rst asserted while opt_valid=1. All outputs return to reset values and the next board parses from IDLE.

Source files
------------

// File: rtl/nonogram_pkg.sv
// Shared protocol definitions for the nonogram line option stream.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nonogram_pkg;

  // Header flag encodings, header bits [7:5]. 3'b011 and 3'b100 are illegal.
  localparam logic [2:0] FLAG_START_BOARD = 3'b111;
  localparam logic [2:0] FLAG_START_LINE  = 3'b110;
  localparam logic [2:0] FLAG_AND         = 3'b101;
  localparam logic [2:0] FLAG_OR          = 3'b010;
  localparam logic [2:0] FLAG_END_LINE    = 3'b001;
  localparam logic [2:0] FLAG_END_BOARD   = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BOARD = 2'd1,
    LINE  = 2'd2,
    ERROR = 2'd3
  } parse_state_t;

endpackage

// File: rtl/option_out_reg.sv
// One-entry valid/ready holding register for an emitted option word.
// Latency: word visible the cycle after load_i.
// Backpressure: word held stable while valid_o && !ready_i; load and drain may coincide.
module option_out_reg #(
  parameter int BITS_W = 16,
  parameter int LINE_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [BITS_W-1:0] bits_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [BITS_W-1:0] bits_o,
  output logic [LINE_W-1:0] line_o,
  output logic              last_o
);

  logic              valid_q, valid_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              last_q, last_d;

  // Load wins over drain so a new word replaces the one leaving in the same cycle.
  always_comb begin
    valid_d = valid_q;
    bits_d  = bits_q;
    line_d  = line_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      bits_d  = bits_i;
      line_d  = line_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry register; reset drops any held word and zeroes the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      bits_q  <= '0;
      line_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      bits_q  <= bits_d;
      line_q  <= line_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign bits_o  = bits_q;
  assign line_o  = line_q;
  assign last_o  = last_q;

endmodule

// File: rtl/line_option_parser.sv
// Parses header/payload byte pairs into per-line option words, counts and board events.
// Latency: payload acceptance to opt_valid/cnt_valid/board_done/m/n/err is 1 cycle.
// Backpressure: in_ready = !opt_valid || opt_ready; nothing changes while in_ready is low.
module line_option_parser #(
  parameter int MAX_N  = 16,
  parameter int OPT_W  = 8,
  parameter int LINE_W = $clog2(2*MAX_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              opt_valid,
  input  logic              opt_ready,
  output logic [MAX_N-1:0]  opt_bits,
  output logic [LINE_W-1:0] opt_line,
  output logic              opt_last,
  output logic              cnt_valid,
  output logic [LINE_W-1:0] cnt_line,
  output logic [OPT_W-1:0]  cnt_value,
  output logic [4:0]        m,
  output logic [4:0]        n,
  output logic              board_done,
  output logic              err
);

  import nonogram_pkg::*;

  localparam logic [OPT_W-1:0] CNT_ONE = OPT_W'(1);

  parse_state_t      state_q, state_d;
  logic              phase_q, phase_d;   // 0: expecting header, 1: expecting payload
  logic [7:0]        hdr_q, hdr_d;
  logic [MAX_N-1:0]  acc_q, acc_d;
  logic [OPT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [4:0]        m_q, m_d, n_q, n_d;
  logic              err_q, err_d;
  logic              cnt_vld_q, cnt_vld_d;
  logic [LINE_W-1:0] cnt_line_q, cnt_line_d;
  logic [OPT_W-1:0]  cnt_value_q, cnt_value_d;
  logic              board_done_q, board_done_d;

  logic              accept;
  logic              emit, emit_last, fail;
  logic [2:0]        flag;
  logic [4:0]        arg;
  logic [7:0]        pos_ext, line_ext, mn_sum, len_ext;
  logic              cnt_full, sizes_ok;

  assign in_ready = !opt_valid || opt_ready;
  assign accept   = in_valid && in_ready;

  assign flag     = hdr_q[7:5];
  assign arg      = hdr_q[4:0];
  assign pos_ext  = {1'b0, in_byte[7:1]};
  assign line_ext = 8'(line_q);
  assign mn_sum   = {3'b000, m_q} + {3'b000, n_q};
  // Rows (index < m) span n cells; columns span m cells.
  assign len_ext  = (line_ext < {3'b000, m_q}) ? {3'b000, n_q} : {3'b000, m_q};
  assign cnt_full = &cnt_q;
  assign sizes_ok = (arg != 5'd0) && (arg <= 5'(MAX_N)) &&
                    (in_byte[4:0] != 5'd0) && (in_byte[4:0] <= 5'(MAX_N));

  // Message decode: headers are latched, the message acts when its payload is accepted.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hdr_d        = hdr_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    m_d          = m_q;
    n_d          = n_q;
    err_d        = err_q;
    cnt_vld_d    = 1'b0;
    cnt_line_d   = cnt_line_q;
    cnt_value_d  = cnt_value_q;
    board_done_d = 1'b0;
    emit         = 1'b0;
    emit_last    = 1'b0;
    fail         = 1'b0;

    if (accept) begin
      if (!phase_q) begin
        // In ERROR only a START_BOARD header can resynchronise the stream.
        if (state_q != ERROR || in_byte[7:5] == FLAG_START_BOARD) begin
          hdr_d   = in_byte;
          phase_d = 1'b1;
          if (in_byte[7:5] == FLAG_START_BOARD) err_d = 1'b0;
        end
      end else begin
        phase_d = 1'b0;
        if (flag == FLAG_START_BOARD) begin
          if (!sizes_ok) begin
            fail = 1'b1;
          end else begin
            m_d     = arg;
            n_d     = in_byte[4:0];
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BOARD;
          end
        end else if (state_q == BOARD || state_q == LINE) begin
          // IDLE silently ignores everything except START_BOARD.
          case (flag)
            FLAG_START_LINE: begin
              if (state_q == LINE || in_byte >= mn_sum) begin
                fail = 1'b1;
              end else begin
                line_d  = in_byte[LINE_W-1:0];
                acc_d   = '0;
                cnt_d   = '0;
                state_d = LINE;
              end
            end
            FLAG_END_BOARD: begin
              if (state_q == LINE) begin
                fail = 1'b1;
              end else begin
                board_done_d = 1'b1;
                state_d      = IDLE;
              end
            end
            FLAG_AND: begin
              if (state_q != LINE || pos_ext >= len_ext) begin
                fail = 1'b1;
              end else begin
                for (int i = 0; i < MAX_N; i++) begin
                  if (pos_ext == 8'(i)) acc_d[i] = in_byte[0];
                end
              end
            end
            FLAG_OR: begin
              if (state_q != LINE || cnt_full) begin
                fail = 1'b1;
              end else begin
                emit  = 1'b1;
                cnt_d = cnt_q + CNT_ONE;
                acc_d = '0;
              end
            end
            FLAG_END_LINE: begin
              if (state_q != LINE || cnt_full) begin
                fail = 1'b1;
              end else begin
                emit        = 1'b1;
                emit_last   = 1'b1;
                cnt_d       = cnt_q + CNT_ONE;
                acc_d       = '0;
                cnt_vld_d   = 1'b1;
                cnt_line_d  = line_q;
                cnt_value_d = cnt_q + CNT_ONE;
                state_d     = BOARD;
              end
            end
            default: fail = 1'b1;
          endcase
        end
      end
    end

    if (fail) begin
      err_d   = 1'b1;
      state_d = ERROR;
      phase_d = 1'b0;
    end
  end

  // Parser state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      hdr_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      line_q       <= '0;
      m_q          <= '0;
      n_q          <= '0;
      err_q        <= 1'b0;
      cnt_vld_q    <= 1'b0;
      cnt_line_q   <= '0;
      cnt_value_q  <= '0;
      board_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      hdr_q        <= hdr_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      m_q          <= m_d;
      n_q          <= n_d;
      err_q        <= err_d;
      cnt_vld_q    <= cnt_vld_d;
      cnt_line_q   <= cnt_line_d;
      cnt_value_q  <= cnt_value_d;
      board_done_q <= board_done_d;
    end
  end

  option_out_reg #(
    .BITS_W (MAX_N),
    .LINE_W (LINE_W)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (emit),
    .bits_i  (acc_q),
    .line_i  (line_q),
    .last_i  (emit_last),
    .ready_i (opt_ready),
    .valid_o (opt_valid),
    .bits_o  (opt_bits),
    .line_o  (opt_line),
    .last_o  (opt_last)
  );

  assign cnt_valid  = cnt_vld_q;
  assign cnt_line   = cnt_line_q;
  assign cnt_value  = cnt_value_q;
  assign m          = m_q;
  assign n          = n_q;
  assign board_done = board_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_line_option_parser.sv
// Directed bench for line_option_parser (default sizing plus an OPT_W=2 copy).
// Latency: n/a.
// Backpressure: opt_ready driven by the bench.
module tb_line_option_parser;

  localparam int MAX_N  = 16;
  localparam int LINE_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_byte = 8'h00;
  logic              in_valid = 1'b0;
  logic              opt_ready = 1'b1;

  logic              in_ready, opt_valid, opt_last, cnt_valid, board_done, err;
  logic [MAX_N-1:0]  opt_bits;
  logic [LINE_W-1:0] opt_line, cnt_line;
  logic [7:0]        cnt_value;
  logic [4:0]        m, n;

  logic              in_ready2, opt_valid2, opt_last2, cnt_valid2, board_done2, err2;
  logic [MAX_N-1:0]  opt_bits2;
  logic [LINE_W-1:0] opt_line2, cnt_line2;
  logic [1:0]        cnt_value2;
  logic [4:0]        m2, n2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [21:0] words[$];   // {bits, line, last}
  logic [12:0] cnts[$];    // {line, value}
  int          bd_cnt = 0;
  int          w2_cnt = 0;
  int          w2_last = 0;

  line_option_parser #(.MAX_N(MAX_N), .OPT_W(8), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .opt_valid(opt_valid), .opt_ready(opt_ready), .opt_bits(opt_bits), .opt_line(opt_line),
    .opt_last(opt_last), .cnt_valid(cnt_valid), .cnt_line(cnt_line), .cnt_value(cnt_value),
    .m(m), .n(n), .board_done(board_done), .err(err)
  );

  line_option_parser #(.MAX_N(MAX_N), .OPT_W(2), .LINE_W(LINE_W)) dut2 (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready2),
    .opt_valid(opt_valid2), .opt_ready(opt_ready), .opt_bits(opt_bits2), .opt_line(opt_line2),
    .opt_last(opt_last2), .cnt_valid(cnt_valid2), .cnt_line(cnt_line2), .cnt_value(cnt_value2),
    .m(m2), .n(n2), .board_done(board_done2), .err(err2)
  );

  always #5 clk = ~clk;

  // Record handshakes and pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (opt_valid && opt_ready) words.push_back({opt_bits, opt_line, opt_last});
    if (cnt_valid) cnts.push_back({cnt_line, cnt_value});
    if (board_done) bd_cnt++;
    if (opt_valid2 && opt_ready) begin
      w2_cnt++;
      if (opt_last2) w2_last++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 50) begin
      n_bad++;
      $display("FAIL send_wait: in_ready=%b for byte %h, want 1 within 50 cycles", in_ready, b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] h, input logic [7:0] p);
    send(h);
    send(p);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    opt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (opt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_opt_valid: got %b want 0", opt_valid); end
    n_cmp++; if ({opt_bits, opt_line, opt_last} !== 22'd0) begin n_bad++; $display("FAIL reset_opt_word: got %h want 0", {opt_bits, opt_line, opt_last}); end
    n_cmp++; if ({cnt_valid, cnt_line, cnt_value} !== 14'd0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", {cnt_valid, cnt_line, cnt_value}); end
    n_cmp++; if ({m, n, board_done, err} !== 12'd0) begin n_bad++; $display("FAIL reset_mn_flags: got %h want 0", {m, n, board_done, err}); end
  endtask

  task automatic test_3x3();
    int wb, cb, bb;
    do_reset();
    wb = words.size(); cb = cnts.size(); bb = bd_cnt;
    send2(8'hE3, 8'h03);
    n_cmp++; if ({m, n} !== {5'd3, 5'd3}) begin n_bad++; $display("FAIL 3x3_mn: got m=%0d n=%0d want 3 3", m, n); end
    send2(8'hC0, 8'h00);
    send2(8'hA0, 8'h01);
    send2(8'hA0, 8'h05);
    send2(8'h40, 8'h00);
    n_cmp++; if (opt_valid !== 1'b1 || opt_bits !== 16'h0005) begin n_bad++; $display("FAIL 3x3_latency: valid=%b bits=%h want 1 0005", opt_valid, opt_bits); end
    send2(8'hA0, 8'h03);
    send2(8'h20, 8'h00);
    n_cmp++; if ({cnt_valid, cnt_line, cnt_value} !== {1'b1, 5'd0, 8'd2}) begin n_bad++; $display("FAIL 3x3_cnt: got %b/%0d/%0d want 1/0/2", cnt_valid, cnt_line, cnt_value); end
    send2(8'h00, 8'h00);
    n_cmp++; if (board_done !== 1'b1) begin n_bad++; $display("FAIL 3x3_board_done: got %b want 1", board_done); end
    idle(3);
    n_cmp++; if (words.size() - wb != 2) begin n_bad++; $display("FAIL 3x3_word_count: got %0d want 2", words.size() - wb); end
    n_cmp++; if (words.size() < wb + 2 || words[wb] !== {16'h0005, 5'd0, 1'b0}) begin n_bad++; $display("FAIL 3x3_word0: want bits 0005 line 0 last 0"); end
    n_cmp++; if (words.size() < wb + 2 || words[wb+1] !== {16'h0002, 5'd0, 1'b1}) begin n_bad++; $display("FAIL 3x3_word1: want bits 0002 line 0 last 1"); end
    n_cmp++; if (cnts.size() - cb != 1) begin n_bad++; $display("FAIL 3x3_cnt_pulses: got %0d want 1", cnts.size() - cb); end
    n_cmp++; if (bd_cnt - bb != 1) begin n_bad++; $display("FAIL 3x3_bd_pulses: got %0d want 1", bd_cnt - bb); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL 3x3_err: got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    int wb;
    int hold_bad;
    do_reset();
    wb = words.size();
    send2(8'hE3, 8'h03);
    send2(8'hC0, 8'h00);
    send2(8'hA0, 8'h01);
    opt_ready = 1'b0;
    send2(8'h40, 8'h00);
    hold_bad = 0;
    fork
      begin
        send2(8'hA0, 8'h03);
        send2(8'h20, 8'h00);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (in_ready !== 1'b0 || opt_valid !== 1'b1 || opt_bits !== 16'h0001 || opt_last !== 1'b0) hold_bad++;
        end
        @(posedge clk);
        #1;
        opt_ready = 1'b1;
      end
    join
    n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL bp_hold: %0d stalled cycles wrong, want 0", hold_bad); end
    idle(3);
    n_cmp++; if (words.size() - wb != 2) begin n_bad++; $display("FAIL bp_word_count: got %0d want 2", words.size() - wb); end
    n_cmp++; if (words.size() < wb + 2 || words[wb] !== {16'h0001, 5'd0, 1'b0}) begin n_bad++; $display("FAIL bp_word0: want bits 0001 line 0 last 0"); end
    n_cmp++; if (words.size() < wb + 2 || words[wb+1] !== {16'h0002, 5'd0, 1'b1}) begin n_bad++; $display("FAIL bp_word1: want bits 0002 line 0 last 1"); end
  endtask

  task automatic test_range_error();
    int wb;
    do_reset();
    wb = words.size();
    send2(8'hE3, 8'h03);
    send2(8'hC0, 8'h00);
    send2(8'hA0, 8'h07);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL range_err_set: got %b want 1", err); end
    send2(8'h40, 8'h00);
    send2(8'h20, 8'h00);
    idle(2);
    n_cmp++; if (words.size() != wb || err !== 1'b1) begin n_bad++; $display("FAIL range_discard: words=%0d err=%b want 0 1", words.size() - wb, err); end
    send2(8'hE3, 8'h03);
    n_cmp++; if ({err, m, n} !== {1'b0, 5'd3, 5'd3}) begin n_bad++; $display("FAIL range_recover: err=%b m=%0d n=%0d want 0 3 3", err, m, n); end
    send2(8'hC0, 8'h01);
    send2(8'hA0, 8'h05);
    send2(8'h20, 8'h00);
    n_cmp++; if ({cnt_valid, cnt_line, cnt_value} !== {1'b1, 5'd1, 8'd1}) begin n_bad++; $display("FAIL range_cnt: got %b/%0d/%0d want 1/1/1", cnt_valid, cnt_line, cnt_value); end
    idle(2);
    n_cmp++; if (words.size() != wb + 1 || words[wb] !== {16'h0004, 5'd1, 1'b1}) begin n_bad++; $display("FAIL range_next_word: count=%0d want 1 word bits 0004 line 1 last 1", words.size() - wb); end
  endtask

  task automatic test_illegal_flag();
    do_reset();
    send2(8'hE3, 8'h03);
    send2(8'hC0, 8'h00);
    send2(8'h60, 8'h00);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_err: got %b want 1", err); end
    send2(8'hE2, 8'h02);
    n_cmp++; if ({err, m, n} !== {1'b0, 5'd2, 5'd2}) begin n_bad++; $display("FAIL illegal_recover: err=%b m=%0d n=%0d want 0 2 2", err, m, n); end
  endtask

  task automatic test_bounds();
    int wb;
    do_reset();
    wb = words.size();
    send2(8'hE3, 8'h03);
    send2(8'hC0, 8'h05);
    send2(8'hA0, 8'h05);
    send2(8'h20, 8'h00);
    idle(2);
    n_cmp++; if (err !== 1'b0 || words.size() != wb + 1 || words[wb] !== {16'h0004, 5'd5, 1'b1}) begin n_bad++; $display("FAIL bounds_last_column: err=%b count=%0d want 0 and bits 0004 line 5 last 1", err, words.size() - wb); end
    send2(8'hC0, 8'h06);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bounds_line_range: err=%b want 1", err); end
    send2(8'hE0, 8'h03);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bounds_m_zero: err=%b want 1", err); end
    send2(8'hE3, 8'h10);
    n_cmp++; if ({err, m, n} !== {1'b0, 5'd3, 5'd16}) begin n_bad++; $display("FAIL bounds_n_max: err=%b m=%0d n=%0d want 0 3 16", err, m, n); end
    send2(8'hE3, 8'h11);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bounds_n_over: err=%b want 1", err); end
  endtask

  task automatic test_overflow();
    int wb, w2b, l2b;
    do_reset();
    wb = words.size(); w2b = w2_cnt; l2b = w2_last;
    send2(8'hE3, 8'h03);
    send2(8'hC0, 8'h00);
    send2(8'h40, 8'h00);
    send2(8'h40, 8'h00);
    send2(8'h40, 8'h00);
    n_cmp++; if (err2 !== 1'b0) begin n_bad++; $display("FAIL ovf_third_or: err2=%b want 0", err2); end
    send2(8'h40, 8'h00);
    n_cmp++; if (err2 !== 1'b1) begin n_bad++; $display("FAIL ovf_fourth_or: err2=%b want 1", err2); end
    send2(8'h20, 8'h00);
    n_cmp++; if ({err, cnt_valid, cnt_value} !== {1'b0, 1'b1, 8'd5}) begin n_bad++; $display("FAIL ovf_wide_cnt: err=%b cnt_valid=%b value=%0d want 0 1 5", err, cnt_valid, cnt_value); end
    n_cmp++; if (cnt_valid2 !== 1'b0) begin n_bad++; $display("FAIL ovf_narrow_cnt: cnt_valid2=%b want 0", cnt_valid2); end
    idle(2);
    n_cmp++; if (w2_cnt - w2b != 3 || w2_last != l2b) begin n_bad++; $display("FAIL ovf_words: got %0d words %0d last want 3 0", w2_cnt - w2b, w2_last - l2b); end
    n_cmp++; if (words.size() - wb != 5) begin n_bad++; $display("FAIL ovf_wide_words: got %0d want 5", words.size() - wb); end
  endtask

  task automatic test_midline_reset();
    int wb, cb;
    do_reset();
    send2(8'hE3, 8'h03);
    send2(8'hC0, 8'h00);
    send2(8'hA0, 8'h01);
    opt_ready = 1'b0;
    send2(8'h40, 8'h00);
    n_cmp++; if (opt_valid !== 1'b1) begin n_bad++; $display("FAIL mid_held: opt_valid=%b want 1", opt_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wb = words.size(); cb = cnts.size();
    n_cmp++; if ({in_ready, opt_valid, opt_bits, opt_last} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin n_bad++; $display("FAIL mid_out_reset: ready=%b valid=%b bits=%h want 1 0 0000", in_ready, opt_valid, opt_bits); end
    n_cmp++; if ({m, n, err} !== 11'd0) begin n_bad++; $display("FAIL mid_state_reset: m=%0d n=%0d err=%b want 0 0 0", m, n, err); end
    opt_ready = 1'b1;
    send2(8'hC0, 8'h00);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mid_idle_ignore: err=%b want 0", err); end
    send2(8'hE2, 8'h02);
    send2(8'hC0, 8'h03);
    send2(8'hA0, 8'h03);
    send2(8'h20, 8'h00);
    idle(2);
    n_cmp++; if (words.size() != wb + 1 || words[wb] !== {16'h0002, 5'd3, 1'b1}) begin n_bad++; $display("FAIL mid_next_word: count=%0d want 1 word bits 0002 line 3 last 1", words.size() - wb); end
    n_cmp++; if (cnts.size() != cb + 1 || cnts[cb] !== {5'd3, 8'd1}) begin n_bad++; $display("FAIL mid_next_cnt: count=%0d want 1 pulse line 3 value 1", cnts.size() - cb); end
  endtask

  initial begin
    test_reset();
    test_3x3();
    test_backpressure();
    test_range_error();
    test_illegal_flag();
    test_bounds();
    test_overflow();
    test_midline_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
